alu_arbiter: RTL and testbench

- Shares the single ALU instance between two requesters: r0 = execute stage, r1 = address/auxiliary unit.
- Round-robin arbitration over valid/ready handshakes.
- Drives registered, stable operands to the ALU, waits the ALU latency, captures result and NZCV, returns them to the granted requester.
- Sits between the pipeline front-end and the ALU; one operation in flight at a time.

---
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request/response handshake bundle.
// Fields: req_valid/req_ready, a, b, op, cin, shift_op, shift_num, setflags, rsp_valid/rsp_ready.
interface alu_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        cin;
    logic [2:0]  shift_op;
    logic [7:0]  shift_num;
    logic        setflags;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (
        output req_valid, a, b, op, cin, shift_op, shift_num, setflags, rsp_ready,
        input  req_ready, rsp_valid
    );

    modport slave (
        input  req_valid, a, b, op, cin, shift_op, shift_num, setflags, rsp_ready,
        output req_ready, rsp_valid
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between execute (r0) and aux unit (r1).
// Ports: CP/reset (async low), r0/r1 request bundles, shared rsp_data/rsp_nzcv,
//   registered alu_* operands out, alu_out/alu_n/z/c/v in, flags_nzcv flag register.
// Optional macro ALU_ARB_FLAGS_EN: flags_nzcv register and carry chaining via flag C.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic         CP,
    input  logic         reset,
    alu_arbiter_if.slave r0,
    alu_arbiter_if.slave r1,
    output logic [31:0]  rsp_data,
    output logic [3:0]   rsp_nzcv,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_cin,
    output logic [2:0]   alu_shift_op,
    output logic [7:0]   alu_shift_num,
    input  logic [31:0]  alu_out,
    input  logic         alu_n,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic [3:0]   flags_nzcv
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic        grant;
    logic        last_grant;
    logic [2:0]  cnt;
    logic        win;
    logic        accept;
    logic        capture;
    logic        rsp_hs;
    logic        cin_eff;

    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_op;
    logic        sel_cin;
    logic [2:0]  sel_sop;
    logic [7:0]  sel_snum;
    logic        sel_setf;

    // Contention goes to whoever was not served last; a lone request wins.
    assign win     = (r0.req_valid & r1.req_valid) ? ~last_grant : r1.req_valid;
    assign accept  = reset & (state == IDLE) & (r0.req_valid | r1.req_valid);
    assign capture = (state == BUSY) & (cnt == 3'd1);
    assign rsp_hs  = (state == RESP) & (grant ? r1.rsp_ready : r0.rsp_ready);

    always_comb begin
        sel_a    = r0.a;
        sel_b    = r0.b;
        sel_op   = r0.op;
        sel_cin  = r0.cin;
        sel_sop  = r0.shift_op;
        sel_snum = r0.shift_num;
        sel_setf = r0.setflags;
        if (win) begin
            sel_a    = r1.a;
            sel_b    = r1.b;
            sel_op   = r1.op;
            sel_cin  = r1.cin;
            sel_sop  = r1.shift_op;
            sel_snum = r1.shift_num;
            sel_setf = r1.setflags;
        end
    end

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)  state_nx = BUSY;
            BUSY:    if (capture) state_nx = RESP;
            RESP:    if (rsp_hs)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        r0.req_ready = 1'b0;
        r1.req_ready = 1'b0;
        r0.rsp_valid = 1'b0;
        r1.rsp_valid = 1'b0;
        if (accept) begin
            r0.req_ready = ~win;
            r1.req_ready = win;
        end
        if (state == RESP) begin
            r0.rsp_valid = ~grant;
            r1.rsp_valid = grant;
        end
    end

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= 3'd0;
            alu_a         <= 32'h0;
            alu_b         <= 32'h0;
            alu_op        <= 4'h0;
            alu_cin       <= 1'b0;
            alu_shift_op  <= 3'h0;
            alu_shift_num <= 8'h0;
            rsp_data      <= 32'h0;
            rsp_nzcv      <= 4'h0;
        end else begin
            if (accept) begin
                grant         <= win;
                last_grant    <= win;
                cnt           <= 3'(ALU_LAT);
                alu_a         <= sel_a;
                alu_b         <= sel_b;
                alu_op        <= sel_op;
                alu_cin       <= cin_eff;
                alu_shift_op  <= sel_sop;
                alu_shift_num <= sel_snum;
            end else if (state == BUSY) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                rsp_data <= alu_out;
                rsp_nzcv <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic setf;

    // Carry-in comes from flag C so ADC/SBC chain across operations.
    assign cin_eff = sel_cin & flags_nzcv[1];

    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            setf       <= 1'b0;
            flags_nzcv <= 4'h0;
        end else begin
            if (accept)
                setf <= sel_setf;
            if (capture && setf)
                flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
        end
    end
`else
    logic unused_setf;

    assign unused_setf = sel_setf;
    assign cin_eff     = sel_cin;
    assign flags_nzcv  = 4'h0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction-level model.
// Includes a behavioural ALU with configurable latency driving the DUT's ALU side.
`timescale 1ns/1ps
module tb_alu_arbiter;
`ifdef ALU_ARB_FLAGS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        CP = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_nzcv;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [2:0]  alu_shift_op;
    logic [7:0]  alu_shift_num;
    logic [31:0] alu_out = 32'h0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic        alu_c = 1'b0;
    logic        alu_v = 1'b0;
    logic [3:0]  flags_nzcv;
    int          n_pass = 0;
    int          n_total = 0;

    alu_arbiter_if rq0 ();
    alu_arbiter_if rq1 ();

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .CP(CP), .reset(reset), .r0(rq0), .r1(rq1),
        .rsp_data(rsp_data), .rsp_nzcv(rsp_nzcv),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_shift_op(alu_shift_op), .alu_shift_num(alu_shift_num),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .alu_v(alu_v), .flags_nzcv(flags_nzcv)
    );

    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference ALU: returns {n,z,c,v,result}; ARM-style carry (no borrow = 1).
    function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] s;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic ci, arith, cf, vf;
        arith = 1'b1; x = a; y = b; ci = 1'b0; r = 32'h0; cf = 1'b0; vf = 1'b0;
        case (op)
            4'd2: begin y = ~b; ci = 1'b1; end
            4'd3: begin x = b; y = ~a; ci = 1'b1; end
            4'd4: ci = 1'b0;
            4'd5: ci = c;
            4'd6: begin y = ~b; ci = c; end
            4'd7: begin x = b; y = ~a; ci = c; end
            default: arith = 1'b0;
        endcase
        s = {1'b0, x} + {1'b0, y} + {32'h0, ci};
        if (arith) begin
            r  = s[31:0];
            cf = s[32];
            vf = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            case (op)
                4'd1:    r = a ^ b;
                4'd12:   r = a | b;
                4'd13:   r = b;
                4'd14:   r = a & ~b;
                4'd15:   r = ~b;
                default: r = a & b;
            endcase
        end
        return {r[31], (r == 32'h0), cf, vf, r};
    endfunction

    // Behavioural ALU: output is garbage until operands have been stable LAT-1 edges.
    logic [68:0] snap = '0;
    int          age = 0;
    always @(negedge CP) begin
        logic [68:0] cur;
        logic [35:0] res;
        cur = {alu_a, alu_b, alu_op, alu_cin};
        if (cur !== snap) begin
            snap = cur;
            age = 0;
        end else if (age < 100) begin
            age++;
        end
        res = alu_f(alu_op, alu_a, alu_b, alu_cin);
        if (age >= LAT - 1) begin
            {alu_n, alu_z, alu_c, alu_v, alu_out} = res;
        end else begin
            {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
            alu_out = 32'hDEAD_BEEF;
        end
    end

    // Transaction model: one op in flight, counted in edges since acceptance.
    bit          m_busy = 1'b0;
    bit          m_id = 1'b0;
    bit          m_last = 1'b1;
    bit          m_setf = 1'b0;
    int          m_age = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_op = '0;
    logic [3:0]  m_nzcv = '0;
    logic [3:0]  m_flags = '0;
    logic        m_cin = 1'b0;
    logic [2:0]  m_sop = '0;
    logic [7:0]  m_snum = '0;

    always @(negedge CP) begin
        bit e_rr0, e_rr1, e_rv0, e_rv1;
        logic [35:0] res;
        if (!reset) begin
            m_busy = 0; m_id = 0; m_last = 1; m_setf = 0; m_age = 0;
            m_a = '0; m_b = '0; m_data = '0; m_op = '0; m_nzcv = '0;
            m_flags = '0; m_cin = 0; m_sop = '0; m_snum = '0;
        end
        e_rv0 = m_busy && (m_age >= LAT) && !m_id;
        e_rv1 = m_busy && (m_age >= LAT) && m_id;
        e_rr0 = reset && !m_busy && rq0.req_valid && (!rq1.req_valid || m_last);
        e_rr1 = reset && !m_busy && rq1.req_valid && (!rq0.req_valid || !m_last);
        chk("m_req_ready0", 64'(rq0.req_ready), 64'(e_rr0));
        chk("m_req_ready1", 64'(rq1.req_ready), 64'(e_rr1));
        chk("m_rsp_valid0", 64'(rq0.rsp_valid), 64'(e_rv0));
        chk("m_rsp_valid1", 64'(rq1.rsp_valid), 64'(e_rv1));
        chk("m_rsp_data", 64'(rsp_data), 64'(m_data));
        chk("m_rsp_nzcv", 64'(rsp_nzcv), 64'(m_nzcv));
        chk("m_alu_a", 64'(alu_a), 64'(m_a));
        chk("m_alu_b", 64'(alu_b), 64'(m_b));
        chk("m_alu_ctl", 64'({alu_op, alu_cin, alu_shift_op, alu_shift_num}),
            64'({m_op, m_cin, m_sop, m_snum}));
        chk("m_flags", 64'(flags_nzcv), 64'(m_flags));
        if (reset) begin
            if (m_busy) begin
                if (m_age >= LAT && (m_id ? rq1.rsp_ready : rq0.rsp_ready)) begin
                    m_busy = 0;
                end else if (m_age < LAT) begin
                    m_age++;
                    if (m_age == LAT) begin
                        res = alu_f(m_op, m_a, m_b, m_cin);
                        m_nzcv = res[35:32];
                        m_data = res[31:0];
`ifdef ALU_ARB_FLAGS_EN
                        if (m_setf) m_flags = m_nzcv;
`endif
                    end
                end
            end else if (e_rr0 || e_rr1) begin
                m_busy = 1; m_age = 0; m_id = e_rr1; m_last = e_rr1;
                if (e_rr1) begin
                    m_a = rq1.a; m_b = rq1.b; m_op = rq1.op; m_cin = rq1.cin;
                    m_sop = rq1.shift_op; m_snum = rq1.shift_num; m_setf = rq1.setflags;
                end else begin
                    m_a = rq0.a; m_b = rq0.b; m_op = rq0.op; m_cin = rq0.cin;
                    m_sop = rq0.shift_op; m_snum = rq0.shift_num; m_setf = rq0.setflags;
                end
`ifdef ALU_ARB_FLAGS_EN
                m_cin = m_cin & m_flags[1];
`endif
            end
        end
    end

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input bit cin,
                           input bit setf, input logic [2:0] sop, input logic [7:0] snum);
        if (id) begin
            rq1.req_valid = v; rq1.op = op; rq1.a = a; rq1.b = b; rq1.cin = cin;
            rq1.setflags = setf; rq1.shift_op = sop; rq1.shift_num = snum;
        end else begin
            rq0.req_valid = v; rq0.op = op; rq0.a = a; rq0.b = b; rq0.cin = cin;
            rq0.setflags = setf; rq0.shift_op = sop; rq0.shift_num = snum;
        end
    endtask

    task automatic clr_reqs();
        rq0.req_valid = 1'b0;
        rq1.req_valid = 1'b0;
    endtask

    task automatic do_op(input bit id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit cin, input bit setf,
                         output logic [31:0] d, output logic [3:0] f, output bit c_seen);
        int n;
        clr_reqs();
        set_req(id, 1'b1, op, a, b, cin, setf, 3'd0, 8'd0);
        if (id) rq1.rsp_ready = 1'b1; else rq0.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!(id ? rq1.req_ready : rq0.req_ready) && n < 30) begin step(); n++; end
        chk("op_accept", 64'(n < 30), 64'(1));
        step();
        clr_reqs();
        c_seen = alu_cin;
        n = 0;
        while (!(id ? rq1.rsp_valid : rq0.rsp_valid) && n < 30) begin step(); n++; end
        chk("op_latency", 64'(n), 64'(LAT));
        d = rsp_data;
        f = rsp_nzcv;
        step();
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_req(input bit id);
        set_req(id, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pick32(), pick32(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  f;
        bit          c;
        bit          g;
        bit          seen;
        int          n;
        set_req(0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'd0);
        set_req(1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 8'd0);
        rq0.rsp_ready = 1'b1;
        rq1.rsp_ready = 1'b1;
        #1 reset = 1'b0;

        // Reset state, then first op: ADD 0xFFFFFFFF + 1
        set_req(0, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 3'd0, 8'd0);
        repeat (3) step();
        chk("rst_req_ready", 64'(rq0.req_ready), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_flags", 64'(flags_nzcv), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        reset = 1'b1;
        #1;
        chk("t1_req_ready0", 64'(rq0.req_ready), 64'(1));
        chk("t1_req_ready1", 64'(rq1.req_ready), 64'(0));
        step();
        rq0.req_valid = 1'b0;
        n = 0;
        while (!rq0.rsp_valid && n < 30) begin step(); n++; end
        chk("t1_latency", 64'(n), 64'(LAT));
        chk("t1_data", 64'(rsp_data), 64'(0));
        chk("t1_nzcv", 64'(rsp_nzcv), 64'(4'b0110));
        chk("t1_rsp_valid1", 64'(rq1.rsp_valid), 64'(0));
        step();

        // Contention: expect r0, r1, r0 from a fresh reset
        reset = 1'b0;
        clr_reqs();
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 4'd4, 32'd10, 32'd20, 1'b0, 1'b0, 3'd0, 8'd0);
        set_req(1, 1'b1, 4'd4, 32'd30, 32'd40, 1'b0, 1'b0, 3'd0, 8'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!(rq0.req_ready || rq1.req_ready) && n < 30) begin step(); n++; end
            g = rq1.req_ready;
            chk("t2_grant", 64'(g), 64'(i % 2));
            step();
            n = 0;
            while (!(rq0.rsp_valid || rq1.rsp_valid) && n < 30) begin step(); n++; end
            chk("t2_owner", 64'({rq1.rsp_valid, rq0.rsp_valid}),
                64'((i % 2 == 1) ? 2'b10 : 2'b01));
            chk("t2_data", 64'(rsp_data), 64'((i % 2 == 1) ? 70 : 30));
            step();
        end
        clr_reqs();

        // Stalled response on r1 blocks a new r0 request
        rq1.rsp_ready = 1'b0;
        set_req(1, 1'b1, 4'd2, 32'h0, 32'h1, 1'b0, 1'b0, 3'd0, 8'd0);
        #1;
        n = 0;
        while (!rq1.req_ready && n < 30) begin step(); n++; end
        chk("t3_accept", 64'(n < 30), 64'(1));
        step();
        rq1.req_valid = 1'b0;
        set_req(0, 1'b1, 4'd4, 32'd5, 32'd6, 1'b0, 1'b0, 3'd0, 8'd0);
        rq0.rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!rq1.rsp_valid && n < 30) begin step(); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("t3_rsp_valid", 64'(rq1.rsp_valid), 64'(1));
            chk("t3_data", 64'(rsp_data), 64'(32'hFFFF_FFFF));
            chk("t3_nzcv", 64'(rsp_nzcv), 64'(4'b1000));
            chk("t3_r0_stall", 64'(rq0.req_ready), 64'(0));
            step();
        end
        rq1.rsp_ready = 1'b1;
        #1;
        step();
        chk("t3_rsp_drop", 64'(rq1.rsp_valid), 64'(0));
        chk("t3_r0_accept", 64'(rq0.req_ready), 64'(1));

        // Reset while busy discards the op
        step();
        rq0.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("t4_rsp_data", 64'(rsp_data), 64'(0));
        chk("t4_nzcv", 64'(rsp_nzcv), 64'(0));
        chk("t4_alu_a", 64'(alu_a), 64'(0));
        chk("t4_alu_b", 64'(alu_b), 64'(0));
        chk("t4_rsp_valid", 64'({rq1.rsp_valid, rq0.rsp_valid}), 64'(0));
        step();
        step();
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (rq0.rsp_valid || rq1.rsp_valid) seen = 1'b1;
        end
        chk("t4_no_rsp", 64'(seen), 64'(0));
        do_op(1, 4'd4, 32'd100, 32'd23, 1'b0, 1'b0, d, f, c);
        chk("t4_next_data", 64'(d), 64'(123));
        chk("t4_next_nzcv", 64'(f), 64'(0));

`ifdef ALU_ARB_FLAGS_EN
        do_op(0, 4'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, d, f, c);
        chk("t5_flags_set", 64'(flags_nzcv), 64'(4'b0110));
        do_op(1, 4'd5, 32'h1, 32'h1, 1'b1, 1'b0, d, f, c);
        chk("t5_alu_cin", 64'(c), 64'(1));
        chk("t5_adc", 64'(d), 64'(3));
        do_op(0, 4'd2, 32'h0, 32'h1, 1'b0, 1'b0, d, f, c);
        chk("t5_raw_nzcv", 64'(f), 64'(4'b1000));
        chk("t5_flags_hold", 64'(flags_nzcv), 64'(4'b0110));
`else
        do_op(0, 4'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, d, f, c);
        chk("t6_raw_nzcv", 64'(f), 64'(4'b0110));
        chk("t6_flags_zero", 64'(flags_nzcv), 64'(0));
        do_op(1, 4'd5, 32'h1, 32'h1, 1'b1, 1'b1, d, f, c);
        chk("t6_cin1", 64'(c), 64'(1));
        chk("t6_adc", 64'(d), 64'(3));
        do_op(0, 4'd5, 32'h1, 32'h1, 1'b0, 1'b1, d, f, c);
        chk("t6_cin0", 64'(c), 64'(0));
        chk("t6_add", 64'(d), 64'(2));
        chk("t6_flags_still", 64'(flags_nzcv), 64'(0));
`endif

        // Random traffic with occasional reset pulses
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset = ($urandom_range(0, 199) != 0);
            rand_req(0);
            rand_req(1);
            rq0.rsp_ready = ($urandom_range(0, 3) != 0);
            rq1.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b1;
        clr_reqs();
        rq0.rsp_ready = 1'b1;
        rq1.rsp_ready = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
